// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Input stage for the 32-point FFT column pipeline. Serial complex samples
//   are collected into 32-sample frames using two ping-pong banks. Each full
//   frame is then presented as one N*W-bit bus for HOLD cycles, which is one
//   full mac_sel sweep of the downstream column MAC stages.
//
//   Build option: define BITREV_EN to store sample k in slot rev5(k), giving
//   bit-reversed input order for the DIT column chain. When it is undefined,
//   samples are stored in natural order.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   s_data       input sample {real[63:32], imag[31:0]}
//   s_valid      s_data valid
//   s_ready      loader can accept a beat (write bank not full)
//   s_last       marks the 32nd sample of a frame
//   frame_data   slot k = frame_data[N*W-1-k*W -: W]; zero when not valid
//   frame_valid  frame_data valid (HOLD cycles per frame)
//   frame_start  one-cycle pulse, first cycle of each valid window
//   frame_done   one-cycle pulse, last cycle of each valid window
//   err_last     sticky framing error (s_last misplaced or missing)
//
// Read FSM states
//   state  | meaning
//   S_IDLE | no full bank pending at rd_bank
//   S_HOLD | presenting bank[rd_bank]; hold_cnt counts 0..HOLD-1

module fft_frame_loader #(
    parameter int N    = 32,
    parameter int W    = 64,
    parameter int HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [N*W-1:0]   frame_data,
    output logic             frame_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             err_last
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [4:0]     wr_idx;
    logic [4:0]     wr_slot;
    logic           wr_bank;
    logic           rd_bank;
    logic [1:0]     full, full_nxt;
    logic           err_q;
    logic [W-1:0]   bank [2][N];

    logic           accept;
    logic           abort;
    logic           complete;
    logic           hold_end;

    assign s_ready  = !full[wr_bank];
    assign accept   = s_valid && s_ready;
    // A premature s_last drops the partial frame; the beat itself is discarded.
    assign abort    = accept && s_last && (wr_idx != 5'd31);
    // The sample count decides completion, even when s_last is missing.
    assign complete = accept && (wr_idx == 5'd31);
    assign hold_end = (state == S_HOLD) && (hold_cnt == CW'(HOLD - 1));
    assign err_last = err_q;

`ifdef BITREV_EN
    assign wr_slot = {wr_idx[0], wr_idx[1], wr_idx[2], wr_idx[3], wr_idx[4]};
`else
    assign wr_slot = wr_idx;
`endif

    // Set and clear never target the same bank: while rd_bank is in HOLD its
    // full flag is high, so the writer cannot be filling that bank.
    always_comb begin
        full_nxt = full;
        if (complete) full_nxt[wr_bank] = 1'b1;
        if (hold_end) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx  <= 5'd0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (hold_end) rd_bank <= !rd_bank;
            if (abort) begin
                err_q  <= 1'b1;
                wr_idx <= 5'd0;
            end else if (complete) begin
                if (!s_last) err_q <= 1'b1;
                wr_idx  <= 5'd0;
                wr_bank <= !wr_bank;
            end else if (accept) begin
                wr_idx <= wr_idx + 5'd1;
            end
        end
    end

    // Sample storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept && !abort) bank[wr_bank][wr_slot] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        frame_valid  = 1'b0;
        frame_start  = 1'b0;
        frame_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt    = S_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            S_HOLD: begin
                frame_valid = 1'b1;
                frame_start = (hold_cnt == '0);
                frame_done  = hold_end;
                if (hold_end) begin
                    hold_cnt_nxt = '0;
                    // Other bank already full (or filling this cycle): go
                    // straight into the next window with no gap cycle.
                    state_nxt = full_nxt[!rd_bank] ? S_HOLD : S_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        frame_data = '0;
        if (state == S_HOLD) begin
            for (int k = 0; k < N; k++) begin
                frame_data[N*W-1-k*W -: W] = bank[rd_bank][5'(k)];
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
//   Directed bench for fft_frame_loader. One instance uses HOLD=4, a second
//   uses HOLD=64 for the ping-pong / back-to-back window sequence.
//   Expected slot contents follow the BITREV_EN build option.

module tb_fft_frame_loader;

    logic           clk = 1'b0;
    logic           reset;
    logic [63:0]    s_data;
    logic           s_last;
    logic           s_valid4, s_valid64;
    logic           s_ready4, s_ready64;
    logic [2047:0]  frame_data4, frame_data64;
    logic           frame_valid4, frame_valid64;
    logic           frame_start4, frame_start64;
    logic           frame_done4, frame_done64;
    logic           err_last4, err_last64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_frame_loader #(.N(32), .W(64), .HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid4),
        .s_ready(s_ready4), .s_last(s_last), .frame_data(frame_data4),
        .frame_valid(frame_valid4), .frame_start(frame_start4),
        .frame_done(frame_done4), .err_last(err_last4)
    );

    fft_frame_loader #(.N(32), .W(64), .HOLD(64)) u_dut64 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid64),
        .s_ready(s_ready64), .s_last(s_last), .frame_data(frame_data64),
        .frame_valid(frame_valid64), .frame_start(frame_start64),
        .frame_done(frame_done64), .err_last(err_last64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] slot(input logic [2047:0] fd, input int k);
        return fd[2047-k*64 -: 64];
    endfunction

    // Sample index expected in slot s.
    function automatic int exp_idx(input int s);
        logic [4:0] v, r;
        v = 5'(s);
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
`ifdef BITREV_EN
        return int'(r);
`else
        return int'(v);
`endif
    endfunction

    task automatic check_idle4(input string tag);
        check({tag, "_ready"}, 64'(s_ready4), 64'd1);
        check({tag, "_valid"}, 64'(frame_valid4), 64'd0);
        check({tag, "_data0"}, 64'(frame_data4 === '0), 64'd1);
    endtask

    initial begin
        int acc;
        logic [31:0] hi;
        reset     = 1'b1;
        s_data    = '0;
        s_last    = 1'b0;
        s_valid4  = 1'b0;
        s_valid64 = 1'b0;

        // 1: reset held 3 cycles, then idle
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle4("rst");
            check("rst_err", 64'(err_last4), 64'd0);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle4("post_rst");
            check("post_rst_err", 64'(err_last4), 64'd0);
        end

        // 2: one clean frame, s_data = {k,k}
        for (int k = 0; k < 32; k++) begin
            s_valid4 = 1'b1;
            s_data   = {32'(k), 32'(k)};
            s_last   = (k == 31);
            check("t2_ready", 64'(s_ready4), 64'd1);
            tick();
        end
        s_valid4 = 1'b0;
        s_last   = 1'b0;
        check("t2_gap_valid", 64'(frame_valid4), 64'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t2_valid", 64'(frame_valid4), 64'd1);
            check("t2_start", 64'(frame_start4), 64'(c == 1));
            check("t2_done", 64'(frame_done4), 64'(c == 4));
        end
        check("t2_top", frame_data4[2047:1984], 64'h0);
        check("t2_bot", frame_data4[63:0], 64'h0000001F_0000001F);
        for (int s = 0; s < 32; s++)
            check("t2_slot", slot(frame_data4, s), {32'(exp_idx(s)), 32'(exp_idx(s))});
        tick();
        check_idle4("t2_after");
        check("t2_err", 64'(err_last4), 64'd0);

        // 4: premature s_last on beat 10, then a clean frame
        for (int k = 0; k <= 10; k++) begin
            s_valid4 = 1'b1;
            s_data   = {32'hDEAD0000 + 32'(k), 32'(k)};
            s_last   = (k == 10);
            tick();
        end
        s_valid4 = 1'b0;
        s_last   = 1'b0;
        check("t4_err_set", 64'(err_last4), 64'd1);
        for (int k = 0; k < 32; k++) begin
            s_valid4 = 1'b1;
            s_data   = {32'hA0 + 32'(k), 32'(k)};
            s_last   = (k == 31);
            check("t4_novalid", 64'(frame_valid4), 64'd0);
            tick();
        end
        s_valid4 = 1'b0;
        s_last   = 1'b0;
        check("t4_gap_valid", 64'(frame_valid4), 64'd0);
        tick();
        check("t4_valid", 64'(frame_valid4), 64'd1);
        check("t4_start", 64'(frame_start4), 64'd1);
        for (int s = 0; s < 32; s++)
            check("t4_slot", slot(frame_data4, s), {32'hA0 + 32'(exp_idx(s)), 32'(exp_idx(s))});
        for (int c = 0; c < 4; c++) tick();
        check("t4_err_sticky", 64'(err_last4), 64'd1);
        check("t4_end_valid", 64'(frame_valid4), 64'd0);

        // 5: reset during second HOLD cycle
        for (int k = 0; k < 32; k++) begin
            s_valid4 = 1'b1;
            s_data   = {32'h5, 32'(k)};
            s_last   = (k == 31);
            tick();
        end
        s_valid4 = 1'b0;
        s_last   = 1'b0;
        tick();
        check("t5_hold1", 64'(frame_valid4), 64'd1);
        tick();
        check("t5_hold2", 64'(frame_valid4), 64'd1);
        reset = 1'b1;
        check("t5_nodone2", 64'(frame_done4), 64'd0);
        tick();
        reset = 1'b0;
        check_idle4("t5_rst");
        check("t5_nodone", 64'(frame_done4), 64'd0);
        check("t5_err_clr", 64'(err_last4), 64'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5_stay_idle", 64'(frame_valid4), 64'd0);
            check("t5_stay_nodone", 64'(frame_done4), 64'd0);
        end

        // missing s_last on beat 31: error, but the frame still completes
        for (int k = 0; k < 32; k++) begin
            s_valid4 = 1'b1;
            s_data   = {32'h77, 32'(k)};
            s_last   = 1'b0;
            tick();
        end
        s_valid4 = 1'b0;
        check("nolast_err", 64'(err_last4), 64'd1);
        tick();
        check("nolast_valid", 64'(frame_valid4), 64'd1);
        check("nolast_slot31", slot(frame_data4, 31), {32'h77, 32'(exp_idx(31))});
        for (int c = 0; c < 4; c++) tick();

        // 3: HOLD=64, 96 beats offered continuously
        acc = 0;
        for (int cyc = 0; cyc < 232; cyc++) begin
            s_valid64 = (acc < 96);
            s_data    = {32'(acc), 32'(acc)};
            s_last    = ((acc % 32) == 31);
            check("t3_ready", 64'(s_ready64),
                  64'(!((cyc >= 64 && cyc <= 96) || (cyc >= 129 && cyc <= 160))));
            check("t3_valid", 64'(frame_valid64), 64'(cyc >= 33 && cyc <= 224));
            check("t3_start", 64'(frame_start64), 64'(cyc == 33 || cyc == 97 || cyc == 161));
            check("t3_done", 64'(frame_done64), 64'(cyc == 96 || cyc == 160 || cyc == 224));
            if (cyc == 33 || cyc == 97 || cyc == 161) begin
                hi = (cyc == 33) ? 32'd0 : (cyc == 97) ? 32'd32 : 32'd64;
                check("t3_slot0", slot(frame_data64, 0), {hi, hi});
                check("t3_slot31", slot(frame_data64, 31), {hi + 32'd31, hi + 32'd31});
                check("t3_slot1", slot(frame_data64, 1),
                      {hi + 32'(exp_idx(1)), hi + 32'(exp_idx(1))});
            end
            if (s_valid64 && s_ready64) acc++;
            tick();
        end
        s_valid64 = 1'b0;
        s_last    = 1'b0;
        check("t3_beats", 64'(acc), 64'd96);
        check("t3_err", 64'(err_last64), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
